// File: rtl/gate_sweep_pkg.sv
// gate_sweep_pkg: shared FSM state type, vector count and NAND3 reference for the sweep checker
package gate_sweep_pkg;
    typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;
    localparam int NVEC = 8;
    function automatic logic nand3(input logic [2:0] v);
        return ~&v;
    endfunction
endpackage

// File: rtl/gate_sweep_timer.sv
// gate_sweep_timer: dwell counter, expire is high in the last of DWELL enabled cycles
module gate_sweep_timer
    import gate_sweep_pkg::*;
#(
    parameter int DWELL = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic en,
    output logic expire
);
    localparam int W = $clog2(DWELL + 1);
    logic [W-1:0] cnt;
    assign expire = en && cnt == W'(DWELL - 1);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt <= '0;
        else if (load) cnt <= '0;
        else if (en && !expire) cnt <= cnt + 1'b1;
endmodule

// File: rtl/gate_sweep_checker.sv
// gate_sweep_checker: sweeps all 8 input vectors of a NAND3 and counts output mismatches
// Optional first-failure log enabled with GATE_SWEEP_ERRLOG_EN.
module gate_sweep_checker
    import gate_sweep_pkg::*;
#(
    parameter int DWELL = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       dut_out,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_cnt
`ifdef GATE_SWEEP_ERRLOG_EN
    ,
    output logic [2:0] first_fail,
    output logic       fail_valid
`endif
);
    state_t state;
    logic [2:0] vec;
    logic expire, miss;
    // vec is cleared on leaving the sweep, so the stimulus rests at 000 outside it
    assign {a, b, c} = vec;
    assign miss = state == SAMPLE && dut_out != nand3(vec);
    gate_sweep_timer #(.DWELL(DWELL)) u_timer (
        .clk(clk),
        .rst_n(rst_n),
        .load(state != DRIVE),
        .en(state == DRIVE),
        .expire(expire)
    );
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state <= IDLE;
            vec <= '0;
            busy <= 1'b0;
            done <= 1'b0;
            pass <= 1'b0;
            err_cnt <= '0;
        end else case (state)
            IDLE: if (start) begin
                state <= DRIVE;
                vec <= '0;
                busy <= 1'b1;
                pass <= 1'b0;
                err_cnt <= '0;
            end
            DRIVE: if (expire) state <= SAMPLE;
            SAMPLE: begin
                err_cnt <= err_cnt + 4'(miss);
                if (vec == 3'(NVEC - 1)) begin
                    state <= DONE;
                    vec <= '0;
                    busy <= 1'b0;
                    done <= 1'b1;
                    pass <= err_cnt == '0 && !miss;
                end else begin
                    state <= DRIVE;
                    vec <= vec + 1'b1;
                end
            end
            default: begin
                state <= IDLE;
                done <= 1'b0;
            end
        endcase
`ifdef GATE_SWEEP_ERRLOG_EN
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            first_fail <= '0;
            fail_valid <= 1'b0;
        end else if (state == IDLE && start) begin
            first_fail <= '0;
            fail_valid <= 1'b0;
        end else if (miss && !fail_valid) begin
            first_fail <= vec;
            fail_valid <= 1'b1;
        end
`endif
endmodule

// File: tb/tb_gate_sweep_checker.sv
// tb_gate_sweep_checker: random fault masks on a modelled NAND3, checked against sweep timing arithmetic
module tb_gate_sweep_checker;
    localparam int D0 = 10;
    localparam int D1 = 1;
    localparam int N0 = 8 * (D0 + 1);
    localparam int P1 = 8 * (D1 + 1) + 2;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start0 = 1'b0;
    logic start1 = 1'b0;
    logic a0, b0, c0, busy0, done0, pass0, dut0;
    logic a1, b1, c1, busy1, done1, pass1, dut1;
    logic [3:0] err0, err1;
    logic [7:0] mask0 = '0;
    logic [7:0] mask1 = '0;
    int checks = 0;
    int errors = 0;
`ifdef GATE_SWEEP_ERRLOG_EN
    logic [2:0] ff0, ff1;
    logic fv0, fv1;
`endif
    always #5 clk = ~clk;
    // a set mask bit flips the modelled gate output for that vector
    assign dut0 = ~(a0 & b0 & c0) ^ mask0[{a0, b0, c0}];
    assign dut1 = ~(a1 & b1 & c1) ^ mask1[{a1, b1, c1}];
    gate_sweep_checker #(.DWELL(D0)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .dut_out(dut0),
        .a(a0), .b(b0), .c(c0), .busy(busy0), .done(done0), .pass(pass0), .err_cnt(err0)
`ifdef GATE_SWEEP_ERRLOG_EN
        , .first_fail(ff0), .fail_valid(fv0)
`endif
    );
    gate_sweep_checker #(.DWELL(D1)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .dut_out(dut1),
        .a(a1), .b(b1), .c(c1), .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err1)
`ifdef GATE_SWEEP_ERRLOG_EN
        , .first_fail(ff1), .fail_valid(fv1)
`endif
    );
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    function automatic int lowest_set(input logic [7:0] m);
        for (int i = 0; i < 8; i++) if (m[i]) return i;
        return 0;
    endfunction
    task automatic check_quiet0(input string tag);
        check({tag, "_abc"}, {a0, b0, c0}, 0);
        check({tag, "_busy"}, busy0, 0);
        check({tag, "_done"}, done0, 0);
    endtask
    task automatic run_sweep0(input logic [7:0] m);
        mask0 = m;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        for (int k = 1; k <= N0; k++) begin
            int vdone;
            vdone = (k - 1) / (D0 + 1);
            check("vec", {a0, b0, c0}, vdone);
            check("busy", busy0, 1);
            check("done_early", done0, 0);
            check("err_running", err0, $countones(m & 8'((1 << vdone) - 1)));
`ifdef GATE_SWEEP_ERRLOG_EN
            if (k == 1) check("fv_cleared", fv0, 0);
`endif
            tick();
        end
        check("done", done0, 1);
        check("busy_at_done", busy0, 0);
        check("pass", pass0, m == 0);
        check("err_cnt", err0, $countones(m));
`ifdef GATE_SWEEP_ERRLOG_EN
        check("fail_valid", fv0, m != 0);
        if (m != 0) check("first_fail", ff0, lowest_set(m));
`endif
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        check_quiet0("start_in_done");
        tick();
        check_quiet0("idle_after");
        check("pass_hold", pass0, m == 0);
        check("err_hold", err0, $countones(m));
    endtask
    initial begin
        int n;
        #1;
        check_quiet0("reset0");
        check("reset0_pass", pass0, 0);
        check("reset0_err", err0, 0);
        check("reset1_busy", busy1, 0);
        check("reset1_abc", {a1, b1, c1}, 0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        tick();
        run_sweep0(8'h00);
        run_sweep0(8'hff);
        run_sweep0(8'h80);
        for (int r = 0; r < 3; r++) begin
            repeat ($urandom_range(0, 3)) tick();
            run_sweep0(8'($urandom));
        end
        // abort a sweep at vector 4 with an asynchronous reset
        mask0 = 8'($urandom) | 8'h01;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        n = 0;
        while ({a0, b0, c0} != 3'd4 && n < 200) begin
            tick();
            n++;
        end
        check("reach_vec4", {a0, b0, c0}, 4);
        #2 rst_n = 1'b0;
        #1;
        check_quiet0("async_rst");
        check("async_rst_pass", pass0, 0);
        check("async_rst_err", err0, 0);
`ifdef GATE_SWEEP_ERRLOG_EN
        check("async_rst_fv", fv0, 0);
        check("async_rst_ff", ff0, 0);
`endif
        @(posedge clk);
        #3 rst_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick();
            check("no_done_after_abort", done0, 0);
            check("no_busy_after_abort", busy0, 0);
        end
        run_sweep0(8'h00);
        // held start on the DWELL=1 instance: back-to-back sweeps
        mask1 = 8'($urandom);
        start1 = 1'b1;
        tick();
        for (int k = 1; k <= 200; k++) begin
            int p;
            p = k % P1;
            check("b2b_done", done1, p == P1 - 1);
            check("b2b_busy", busy1, p >= 1 && p <= P1 - 2);
            if (p >= 1 && p <= P1 - 2) check("b2b_vec", {a1, b1, c1}, (p - 1) / (D1 + 1));
            if (p == P1 - 1) begin
                check("b2b_err", err1, $countones(mask1));
                check("b2b_pass", pass1, mask1 == 0);
`ifdef GATE_SWEEP_ERRLOG_EN
                check("b2b_fv", fv1, mask1 != 0);
                if (mask1 != 0) check("b2b_ff", ff1, lowest_set(mask1));
`endif
            end
            tick();
        end
        start1 = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
